// File: rtl/operand_fetch_pipe.sv
// -----------------------------------------------------------------------------
// operand_fetch_pipe
//   Single-stage operand fetch. The presented instruction is decoded, its
//   sources are read from the register file in the same cycle and the result
//   is captured into one output register with a valid/ready handshake. A
//   16-entry busy scoreboard stalls instructions whose sources have writes
//   still outstanding downstream.
//
// Optional feature (macro OPERAND_FETCH_PIPE_BYPASS_EN):
//   defined   - a source matching the writeback port takes wb_data, and the
//               busy bit of that register does not stall the instruction.
//   undefined - operands come only from rf_rd1/rf_rd2.
//
// Ports
//   clk, reset_n               clock, synchronous active-low reset
//   in_valid / in_ready        upstream handshake
//   instruction, pc_current    instruction word and its PC
//   p, isst, is_wb             link-read select, store select, writes rd
//   rf_ra1/rf_ra2 -> rf_rd1/2  combinational register-file read port
//   wb_valid, wb_rd, wb_data   writeback notification (clears busy)
//   flush                      kill the instruction held in the output reg
//   out_valid / out_ready      downstream handshake
//   opcode, i, rd, immx, branchtarget, op1, op2, out_wb, illegal
//                              registered payload
// -----------------------------------------------------------------------------
module operand_fetch_pipe #(
    parameter int         DATA_W   = 32,
    parameter logic [3:0] LINK_REG = 4'b1111
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc_current,
    input  logic              p,
    input  logic              isst,
    input  logic              is_wb,
    output logic [3:0]        rf_ra1,
    output logic [3:0]        rf_ra2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    input  logic              wb_valid,
    input  logic [3:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        opcode,
    output logic              i,
    output logic [3:0]        rd,
    output logic [DATA_W-1:0] immx,
    output logic [DATA_W-1:0] branchtarget,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic              out_wb,
    output logic              illegal
);

    // Immediate extension selected by the 2-bit modifier; modifier 11 is
    // reserved and yields zero (flagged illegal separately).
    function automatic logic [DATA_W-1:0] ext_imm(input logic [1:0]  mod,
                                                  input logic [15:0] imm);
        logic [31:0] hi;
        hi = {imm, 16'h0000};
        case (mod)
            2'b00:   ext_imm = {{(DATA_W-16){imm[15]}}, imm};
            2'b01:   ext_imm = DATA_W'(imm);
            2'b10:   ext_imm = DATA_W'(hi);
            default: ext_imm = '0;
        endcase
    endfunction

    // Word-aligned branch displacement, sign-extended to the datapath width.
    function automatic logic signed [DATA_W-1:0] branch_disp(input logic [26:0] off);
        logic signed [28:0] off_s;
        off_s = $signed({off, 2'b00});
        branch_disp = {{(DATA_W-29){off_s[28]}}, off_s};
    endfunction

    logic              out_valid_q, out_valid_d;
    logic [15:0]       busy_q, busy_d;
    logic [4:0]        opcode_q, opcode_d;
    logic              i_q, i_d;
    logic [3:0]        rd_q, rd_d;
    logic [DATA_W-1:0] immx_q, immx_d;
    logic [DATA_W-1:0] branchtarget_q, branchtarget_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic              out_wb_q, out_wb_d;
    logic              illegal_q, illegal_d;

    logic              byp1, byp2;
    logic              hazard, accept, xfer;
    logic signed [DATA_W-1:0] br_off;

    assign rf_ra1 = p    ? LINK_REG           : instruction[21:18];
    assign rf_ra2 = isst ? instruction[25:22] : instruction[17:14];

    always_comb begin
`ifdef OPERAND_FETCH_PIPE_BYPASS_EN
        byp1 = wb_valid & (wb_rd == rf_ra1);
        byp2 = wb_valid & (wb_rd == rf_ra2);
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
        // The instruction still sitting in the output register has not yet
        // set its busy bit, so its rd is checked directly.
        hazard = (busy_q[rf_ra1] & ~byp1)
               | (busy_q[rf_ra2] & ~byp2)
               | (out_valid_q & out_wb_q & ((rd_q == rf_ra1) | (rd_q == rf_ra2)));

        in_ready = reset_n & ~hazard & (~out_valid_q | out_ready) & ~flush;
        accept   = in_valid & in_ready;
        // A flushed instruction is never considered delivered.
        xfer     = out_valid_q & out_ready & ~flush;

        // Clear first, then set: a simultaneous set of the same bit wins.
        busy_d = busy_q;
        if (wb_valid)
            busy_d[wb_rd] = 1'b0;
        if (xfer & out_wb_q)
            busy_d[rd_q] = 1'b1;

        if (flush)
            out_valid_d = 1'b0;
        else if (accept)
            out_valid_d = 1'b1;
        else if (out_ready)
            out_valid_d = 1'b0;
        else
            out_valid_d = out_valid_q;

        br_off = branch_disp(instruction[26:0]);

        opcode_d       = opcode_q;
        i_d            = i_q;
        rd_d           = rd_q;
        immx_d         = immx_q;
        branchtarget_d = branchtarget_q;
        op1_d          = op1_q;
        op2_d          = op2_q;
        out_wb_d       = out_wb_q;
        illegal_d      = illegal_q;
        if (accept) begin
            opcode_d       = instruction[31:27];
            i_d            = instruction[26];
            rd_d           = instruction[25:22];
            immx_d         = instruction[26] ? ext_imm(instruction[17:16], instruction[15:0]) : '0;
            illegal_d      = instruction[26] & (instruction[17:16] == 2'b11);
            branchtarget_d = pc_current + $unsigned(br_off);
            op1_d          = byp1 ? wb_data : rf_rd1;
            op2_d          = byp2 ? wb_data : rf_rd2;
            out_wb_d       = is_wb;
        end
    end

    // ---- output register / scoreboard ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q    <= 1'b0;
            busy_q         <= '0;
            opcode_q       <= '0;
            i_q            <= 1'b0;
            rd_q           <= '0;
            immx_q         <= '0;
            branchtarget_q <= '0;
            op1_q          <= '0;
            op2_q          <= '0;
            out_wb_q       <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            busy_q         <= busy_d;
            opcode_q       <= opcode_d;
            i_q            <= i_d;
            rd_q           <= rd_d;
            immx_q         <= immx_d;
            branchtarget_q <= branchtarget_d;
            op1_q          <= op1_d;
            op2_q          <= op2_d;
            out_wb_q       <= out_wb_d;
            illegal_q      <= illegal_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign opcode       = opcode_q;
    assign i            = i_q;
    assign rd           = rd_q;
    assign immx         = immx_q;
    assign branchtarget = branchtarget_q;
    assign op1          = op1_q;
    assign op2          = op2_q;
    assign out_wb       = out_wb_q;
    assign illegal      = illegal_q;

endmodule

// File: doc/operand_fetch_pipe.md
OPERAND_FETCH_PIPE -- requirements
Module: operand_fetch_pipe

Interface
REQ-001 Parameter DATA_W, default 32, operand/immediate/target width; SHALL be >= 32.
REQ-002 Parameter LINK_REG, default 4'b1111, register read on port 1 when p=1.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 in_valid / in_ready  in / out  1 / 1  upstream handshake.
REQ-006 instruction  in  32  [31:27] opcode, [26] i, [25:22] rd, [21:18] rs1, [17:14] rs2, [17:16] imm modifier, [15:0] imm, [26:0] branch offset.
REQ-007 pc_current  in  DATA_W  PC of presented instruction.
REQ-008 p, isst, is_wb  in  1 each  link-read select, store select, instruction writes rd.
REQ-009 rf_ra1, rf_ra2  out  4  combinational register-file read addresses.
REQ-010 rf_rd1, rf_rd2  in  DATA_W  same-cycle read data.
REQ-011 wb_valid, wb_rd, wb_data  in  1, 4, DATA_W  writeback notification.
REQ-012 flush  in  1  kill instruction held in output register.
REQ-013 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-014 opcode 5, i 1, rd 4, immx DATA_W, branchtarget DATA_W, op1 DATA_W, op2 DATA_W, out_wb 1, illegal 1  out  registered payload.

Function
REQ-015 rf_ra1 SHALL be LINK_REG when p=1, else instruction[21:18]; rf_ra2 SHALL be instruction[25:22] when isst=1, else instruction[17:14].
REQ-016 immx (i=1): modifier 00 sign-extend imm[15:0]; 01 zero-extend; 10 imm<<16, zero-extended; 11 immx=0 and illegal=1.
REQ-017 immx SHALL be 0 when i=0; illegal SHALL be 0 unless REQ-016 case 11.
REQ-018 branchtarget SHALL be pc_current + sign-extend(instruction[26:0]<<2) to DATA_W, modulo 2^DATA_W.
REQ-019 Scoreboard: 16 busy bits; bit rd set when the output register transfers (out_valid & out_ready) with out_wb=1; bit wb_rd cleared on wb_valid.
REQ-020 Same-cycle set and clear of the same bit SHALL leave it set; clear of a non-busy bit SHALL be ignored.
REQ-021 hazard SHALL be 1 when busy[rf_ra1] or busy[rf_ra2], or out_valid & out_wb & rd equals rf_ra1 or rf_ra2.
REQ-022 in_ready SHALL equal !hazard & (!out_valid | out_ready) & !flush.
REQ-023 On in_valid & in_ready the payload SHALL load and out_valid SHALL be 1 next cycle; latency exactly 1 cycle.
REQ-024 out_valid & !out_ready SHALL hold every payload bit stable.
REQ-025 out_valid SHALL clear when transfer occurs without a new accept.
REQ-026 flush SHALL clear out_valid next cycle, block acceptance that cycle, and not update the scoreboard for the killed instruction.
REQ-027 Register 0 SHALL have no special treatment.

Reset
REQ-028 reset_n=0 at a clock edge SHALL clear out_valid, all busy bits, and all payload outputs to 0.
REQ-029 in_ready SHALL be 0 while reset_n=0; reset mid-transfer SHALL discard the held instruction.

Configuration
REQ-030 Macro OPERAND_FETCH_PIPE_BYPASS_EN defined: a source matching wb_rd with wb_valid=1 SHALL take wb_data instead of rf_rd and SHALL not count busy[that reg] toward hazard.
REQ-031 Macro undefined: op1/op2 SHALL come only from rf_rd1/rf_rd2 and wb_rd match SHALL not relieve hazard.

Verification
REQ-032 instr i=1, mod 00, imm 16'hFFFE, pc 32'h100 -> next cycle out_valid=1, immx 32'hFFFFFFFE, branchtarget = 32'h100 + sext(offset<<2).
REQ-033 mod 10, imm 16'h1234 -> immx 32'h12340000; mod 11 -> immx 0, illegal=1.
REQ-034 issue is_wb rd=3 then rs1=3 -> in_ready=0 until wb_valid wb_rd=3; with BYPASS_EN op1=wb_data same cycle accepted.
REQ-035 out_ready=0 for 3 cycles -> payload constant, in_ready=0; then out_ready=1 -> one transfer, busy[rd] set.
REQ-036 p=1 -> rf_ra1=4'hF; isst=1, rd=5 -> rf_ra2=5.
REQ-037 flush with out_valid=1 -> out_valid=0 next cycle, scoreboard unchanged; reset_n=0 -> all outputs 0.
